// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for param_register_file and its read-port sub-module:
//   - fixed register indices (ZERO, IMM) and the BRANCH index helper
//   - read-port-1 mode encodings carried on set_ctrl
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned ZERO_IDX = 0;
    localparam int unsigned IMM_IDX  = 1;

    // set_ctrl encodings; 2'b01 also decodes as normal (only bit 1 selects a mode).
    typedef enum logic [1:0] {
        SET_NORMAL = 2'b00,
        SET_IMM    = 2'b10,
        SET_BRANCH = 2'b11
    } set_mode_e;

    // BRANCH is always the last register of the file.
    function automatic int unsigned branch_idx(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of param_register_file: resolves the effective
// address (raw address, or IMM/BRANCH in set modes) and returns the stored value.
// Optional macro REGFILE_BYPASS_EN: forward the in-flight write (and the carry
// force of IMM to 1) to the port in the same cycle. Swaps are never forwarded.
// Ports:
//   regs       in   NUM_REGS x DATA_W  current register contents
//   addr       in   ADDR_W             raw read address
//   set_ctrl   in   2                  mode (tie to SET_NORMAL for a plain port)
//   write_ctrl in   1                  write enable of the file (bypass only)
//   carry_out  in   1                  carry flag (bypass only)
//   write_reg  in   ADDR_W             write address (bypass only)
//   write_val  in   DATA_W             write data (bypass only)
//   read_val   out  DATA_W             read data
// -----------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        set_ctrl,
    input  logic              write_ctrl,
    input  logic              carry_out,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_val,
    output logic [DATA_W-1:0] read_val
);

    localparam logic [ADDR_W-1:0] IMM_A    = ADDR_W'(IMM_IDX);
    localparam logic [ADDR_W-1:0] BRANCH_A = ADDR_W'(branch_idx(NUM_REGS));

    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] stored_val;

    always_comb begin
        eff_addr = addr;
        if (set_ctrl == SET_IMM) begin
            eff_addr = IMM_A;
        end else if (set_ctrl == SET_BRANCH) begin
            eff_addr = BRANCH_A;
        end
    end

    assign stored_val = regs[eff_addr];

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    // Carry forcing beats the written value on IMM, mirroring the write path.
    always_comb begin
        read_val = stored_val;
        if (write_ctrl && (eff_addr != ZERO_A)) begin
            if (carry_out && (eff_addr == IMM_A)) begin
                read_val = DATA_W'(1);
            end else if (write_reg == eff_addr) begin
                read_val = write_val;
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{write_ctrl, carry_out, write_reg, write_val};
    assign read_val      = stored_val;
`endif

endmodule

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// NUM_REGS x DATA_W register file: two combinational read ports, one write
// port, atomic two-register swap, carry-driven set of IMM, set-mode override
// on read port 1 and a dedicated BRANCH tap.
// Register map: 0 = ZERO (reads 0, never written), 1 = IMM,
// NUM_REGS-1 = BRANCH, others general purpose.
// Per-register priority: reset > swap > carry-IMM > write.
// Optional macro REGFILE_BYPASS_EN: same-cycle write forwarding on read ports.
// Ports:
//   clock       in   1       rising-edge clock
//   reset       in   1       synchronous active-high reset (clears all regs)
//   write_ctrl  in   1       write enable
//   carry_out   in   1       forces IMM to 1 on a write cycle
//   swap_ctrl   in   1       exchange reg[read_reg1] and reg[read_reg2]
//   set_ctrl    in   2       port-1 mode: 0x normal, 10 IMM, 11 BRANCH
//   read_reg1   in   ADDR_W  port-1 address
//   read_reg2   in   ADDR_W  port-2 address
//   write_reg   in   ADDR_W  write address
//   write_val   in   DATA_W  write data
//   read_val1   out  DATA_W  port-1 data
//   read_val2   out  DATA_W  port-2 data
//   branch_val  out  DATA_W  BRANCH register contents
// -----------------------------------------------------------------------------
module param_register_file
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = 8,
    parameter  int unsigned NUM_REGS = 8,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_ctrl,
    input  logic              carry_out,
    input  logic              swap_ctrl,
    input  logic [1:0]        set_ctrl,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_val,
    output logic [DATA_W-1:0] read_val1,
    output logic [DATA_W-1:0] read_val2,
    output logic [DATA_W-1:0] branch_val
);

    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] IMM_A    = ADDR_W'(IMM_IDX);
    localparam logic [ADDR_W-1:0] BRANCH_A = ADDR_W'(branch_idx(NUM_REGS));

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Later assignments override earlier ones, giving swap > carry-IMM > write.
    // Re-clearing ZERO last drops writes and the ZERO half of a swap; the other
    // half still picks up ZERO's pre-edge value (always 0).
    always_comb begin
        regs_d = regs_q;
        if (write_ctrl) begin
            regs_d[write_reg] = write_val;
            if (carry_out) begin
                regs_d[IMM_A] = DATA_W'(1);
            end
        end
        if (swap_ctrl && (read_reg1 != read_reg2)) begin
            regs_d[read_reg1] = regs_q[read_reg2];
            regs_d[read_reg2] = regs_q[read_reg1];
        end
        regs_d[ZERO_A] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_read_port1 (
        .regs       (regs_q),
        .addr       (read_reg1),
        .set_ctrl   (set_ctrl),
        .write_ctrl (write_ctrl),
        .carry_out  (carry_out),
        .write_reg  (write_reg),
        .write_val  (write_val),
        .read_val   (read_val1)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_read_port2 (
        .regs       (regs_q),
        .addr       (read_reg2),
        .set_ctrl   (SET_NORMAL),
        .write_ctrl (write_ctrl),
        .carry_out  (carry_out),
        .write_reg  (write_reg),
        .write_val  (write_val),
        .read_val   (read_val2)
    );

    assign branch_val = regs_q[BRANCH_A];

endmodule
